multi_port_reg_file: RTL and testbench

MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

---
 rtl/multi_port_reg_file.sv | 87 ++++++++
 tb/tb_multi_port_reg_file.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_reg_file.sv
// Multi-port register file with write-to-read forwarding and a pending-write
// scoreboard. Reads are combinational; the write and the scoreboard update on
// the rising clock edge. Asserting the active-low reset clears everything at once.
module multi_port_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [AW-1:0]                        wr_reg,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [NUM_RD-1:0][AW-1:0]            rd_reg,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]                    rd_busy,
  input  logic                                 rsv_en,
  input  logic [AW-1:0]                        rsv_reg,
  output logic [DEPTH-1:0]                     busy_vec
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy_next;
  logic                  wr_store;
  logic                  wr_live;

  // Writes to the hardwired zero register are dropped before they reach storage.
  assign wr_store = wr_en && !((ZERO_REG != 0) && (wr_reg == '0));
  // Forwarding is gated by reset so that outputs read zero while reset is held.
  assign wr_live  = wr_en && rst_n;

  // Register storage: asynchronous clear, then one write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_store) begin
      mem[wr_reg] <= wr_data;
    end
  end

  // Scoreboard next state: writeback clears first, so a reservation of the
  // same register in the same cycle overrides it and the bit ends up set.
  always_comb begin
    busy_next = busy_vec;
    if (wr_en) begin
      busy_next[wr_reg] = 1'b0;
    end
    if (rsv_en) begin
      busy_next[rsv_reg] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  // Per-port combinational read with optional forwarding; zero register wins last.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[i] = mem[rd_reg[i]];
      rd_busy[i] = busy_vec[rd_reg[i]];
      if ((BYPASS != 0) && wr_live && (wr_reg == rd_reg[i])) begin
        rd_data[i] = wr_data;
        rd_busy[i] = 1'b0;
      end
      if ((ZERO_REG != 0) && (rd_reg[i] == '0)) begin
        rd_data[i] = '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_reg_file.sv
// Scoreboard bench for multi_port_reg_file. Three instances share stimulus:
// A = defaults, B = forwarding disabled, C = 64-bit / 16-deep / 3 read ports.
// Stimulus queues hand-computed expectations; a negedge monitor pops and checks.
module tb_multi_port_reg_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            wr_en = 1'b0;
  logic            rsv_en = 1'b0;
  logic [4:0]      wr_reg = '0;
  logic [4:0]      rsv_reg = '0;
  logic [31:0]     wr_data = '0;
  logic [1:0][4:0] rd_reg = '0;

  logic [1:0][31:0] rd_data_a, rd_data_b;
  logic [1:0]       rd_busy_a, rd_busy_b;
  logic [31:0]      busy_vec_a, busy_vec_b;

  logic [3:0]       wr_reg_c, rsv_reg_c;
  logic [63:0]      wr_data_c;
  logic [2:0][3:0]  rd_reg_c;
  logic [2:0][63:0] rd_data_c;
  logic [2:0]       rd_busy_c;
  logic [15:0]      busy_vec_c;

  assign wr_reg_c    = wr_reg[3:0];
  assign rsv_reg_c   = rsv_reg[3:0];
  assign wr_data_c   = {wr_data, wr_data};
  assign rd_reg_c[0] = rd_reg[0][3:0];
  assign rd_reg_c[1] = rd_reg[1][3:0];
  assign rd_reg_c[2] = rd_reg[0][3:0];

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    int          dut;
    int          kind;  // 0 rd_data, 1 rd_busy, 2 busy_vec
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  multi_port_reg_file #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg(rd_reg), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy_vec(busy_vec_a)
  );

  multi_port_reg_file #(.DATA_WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rd_reg(rd_reg), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy_vec(busy_vec_b)
  );

  multi_port_reg_file #(.DATA_WIDTH(64), .DEPTH(16), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg_c), .wr_data(wr_data_c),
    .rd_reg(rd_reg_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg_c), .busy_vec(busy_vec_c)
  );

  function automatic logic [63:0] actual(int d, int k, int p);
    case (d)
      0: case (k)
           0: return {32'b0, rd_data_a[p]};
           1: return {63'b0, rd_busy_a[p]};
           default: return {32'b0, busy_vec_a};
         endcase
      1: case (k)
           0: return {32'b0, rd_data_b[p]};
           1: return {63'b0, rd_busy_b[p]};
           default: return {32'b0, busy_vec_b};
         endcase
      default: case (k)
           0: return rd_data_c[p];
           1: return {63'b0, rd_busy_c[p]};
           default: return {48'b0, busy_vec_c};
         endcase
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, so drain all queued expectations here.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [63:0] got;
      e   = q.pop_front();
      got = actual(e.dut, e.kind, e.port);
      tests++;
      if (got !== e.exp) begin
        fails++;
        $display("FAIL %s dut%0d kind%0d port%0d: got %h expected %h",
                 e.name, e.dut, e.kind, e.port, got, e.exp);
      end
    end
  end

  task automatic push(string nm, int d, int k, int p, logic [63:0] v);
    exp_t e;
    e.name = nm; e.dut = d; e.kind = k; e.port = p; e.exp = v;
    q.push_back(e);
  endtask

  // Read-data expectation: A (forwarding), B (no forwarding), C mirrors A at 64 bits.
  task automatic exp_rd(string nm, int p, logic [31:0] ea, logic [31:0] eb);
    push(nm, 0, 0, p, {32'b0, ea});
    push(nm, 1, 0, p, {32'b0, eb});
    push(nm, 2, 0, p, {ea, ea});
    if (p == 0) push(nm, 2, 0, 2, {ea, ea});
  endtask

  task automatic exp_rbusy(string nm, int p, logic ea, logic eb);
    push(nm, 0, 1, p, {63'b0, ea});
    push(nm, 1, 1, p, {63'b0, eb});
    push(nm, 2, 1, p, {63'b0, ea});
    if (p == 0) push(nm, 2, 1, 2, {63'b0, ea});
  endtask

  task automatic exp_bvec(string nm, logic [31:0] v);
    push(nm, 0, 2, 0, {32'b0, v});
    push(nm, 1, 2, 0, {32'b0, v});
    push(nm, 2, 2, 0, {48'b0, v[15:0]});
  endtask

  task automatic drive(logic we, logic [4:0] wr, logic [31:0] wd,
                       logic re, logic [4:0] rr, logic [4:0] r0, logic [4:0] r1);
    wr_en = we; wr_reg = wr; wr_data = wd;
    rsv_en = re; rsv_reg = rr;
    rd_reg[0] = r0; rd_reg[1] = r1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Held in reset with write/reserve requests that must be ignored.
    drive(1'b1, 5'd5, 32'hAAAA5555, 1'b1, 5'd4, 5'd5, 5'd4);
    cyc();
    exp_rd("rst_rd", 0, 32'h0, 32'h0);
    exp_rd("rst_rd", 1, 32'h0, 32'h0);
    exp_rbusy("rst_rbusy", 0, 1'b0, 1'b0);
    exp_rbusy("rst_rbusy", 1, 1'b0, 1'b0);
    exp_bvec("rst_vec", 32'h0);

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd6);

    // Write-then-read.
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    exp_rd("wr_rd_x5", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_rd("wr_rd_x6", 1, 32'h0, 32'h0);
    exp_bvec("wr_nonbusy", 32'h0);

    // Zero register.
    cyc(); drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    exp_rd("zero_same", 0, 32'h0, 32'h0);
    exp_rd("zero_same", 1, 32'h0, 32'h0);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    exp_rd("zero_next", 0, 32'h0, 32'h0);
    exp_rbusy("zero_rbusy", 0, 1'b0, 1'b0);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    exp_bvec("zero_vec", 32'h0);

    // Forwarding versus old value.
    cyc(); drive(1'b1, 5'd7, 32'h11110000, 1'b0, 5'd0, 5'd7, 5'd7);
    exp_rd("byp_first", 0, 32'h11110000, 32'h0);
    exp_rd("byp_first", 1, 32'h11110000, 32'h0);
    cyc(); drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7);
    exp_rd("byp_same", 0, 32'h12345678, 32'h11110000);
    exp_rd("byp_same", 1, 32'h12345678, 32'h11110000);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    exp_rd("byp_next", 0, 32'h12345678, 32'h12345678);
    exp_rd("byp_next", 1, 32'h12345678, 32'h12345678);

    // Scoreboard: reserve, writeback, simultaneous reserve+write, re-reserve.
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7);
    exp_rbusy("rsv_pre", 0, 1'b0, 1'b0);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    exp_rbusy("rsv_busy", 0, 1'b1, 1'b1);
    exp_rbusy("rsv_busy", 1, 1'b1, 1'b1);
    exp_bvec("rsv_vec", 32'h8);
    cyc(); drive(1'b1, 5'd3, 32'hCAFE0003, 1'b0, 5'd0, 5'd3, 5'd3);
    exp_rbusy("wb_rbusy", 0, 1'b0, 1'b1);
    exp_rd("wb_data", 0, 32'hCAFE0003, 32'h0);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    exp_rbusy("wb_after", 0, 1'b0, 1'b0);
    exp_bvec("wb_vec", 32'h0);
    exp_rd("wb_after", 1, 32'hCAFE0003, 32'hCAFE0003);
    cyc(); drive(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3, 5'd3, 5'd2);
    exp_rd("rsvwr_data", 0, 32'h33333333, 32'hCAFE0003);
    exp_rd("rsvwr_x2", 1, 32'h0, 32'h0);
    exp_rbusy("rsvwr_rbusy", 0, 1'b0, 1'b0);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    exp_bvec("set_wins", 32'h8);
    exp_rbusy("set_wins", 0, 1'b1, 1'b1);
    exp_rd("set_wins", 0, 32'h33333333, 32'h33333333);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    exp_bvec("rersv_vec", 32'h8);

    // Fill x1..x31 with 0x100 + (i mod 16) so the 16-deep instance aliases consistently.
    for (int i = 1; i < 32; i++) begin
      cyc(); drive(1'b1, 5'(i), 32'h100 + 32'(i % 16), 1'b0, 5'd0, 5'd0, 5'd0);
    end
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 5'd31);
    exp_rd("fill_x10", 0, 32'h10A, 32'h10A);
    exp_rd("fill_x31", 1, 32'h10F, 32'h10F);
    exp_rbusy("fill_rsv_pre", 0, 1'b0, 1'b0);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd10);
    exp_rd("fill_x1", 0, 32'h101, 32'h101);
    exp_rbusy("fill_x10_busy", 1, 1'b1, 1'b1);
    exp_bvec("fill_vec", 32'h400);

    // Asynchronous reset between edges.
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd31);
    #2;
    rst_n = 1'b0;
    exp_rd("arst_rd", 0, 32'h0, 32'h0);
    exp_rd("arst_rd", 1, 32'h0, 32'h0);
    exp_rbusy("arst_rbusy", 0, 1'b0, 1'b0);
    exp_rbusy("arst_rbusy", 1, 1'b0, 1'b0);
    exp_bvec("arst_vec", 32'h0);

    // First edge after deassertion accepts a write; reservation is gone.
    cyc();
    rst_n = 1'b1;
    drive(1'b1, 5'd9, 32'h00009999, 1'b0, 5'd0, 5'd9, 5'd10);
    exp_rd("post_rst_byp", 0, 32'h00009999, 32'h0);
    exp_rd("post_rst_x10", 1, 32'h0, 32'h0);
    exp_rbusy("post_rst_rbusy", 1, 1'b0, 1'b0);
    exp_bvec("post_rst_vec", 32'h0);
    cyc(); drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10);
    exp_rd("post_rst_wr", 0, 32'h00009999, 32'h00009999);
    exp_bvec("post_rst_vec2", 32'h0);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, expected 0", q.size());
      tests += q.size();
      fails += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
